// File: rtl/dec_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for dec_stage.
// The slave modport is the decoder's view; master is the fetch/execute side.
interface dec_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] imm;
  logic [3:0]      alu_op;
  logic [3:0]      inst_type;
  logic [3:0]      mem_wbmask;
  logic [1:0]      mem_size;
  logic            is_mem_sign;
  logic            mem_wen;
  logic            illegal;
  logic            halt;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, rd, rs1, rs2, imm, alu_op,
           inst_type, mem_wbmask, mem_size, is_mem_sign, mem_wen,
           illegal, halt
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, rd, rs1, rs2, imm, alu_op,
           inst_type, mem_wbmask, mem_size, is_mem_sign, mem_wen,
           illegal, halt
  );
endinterface

// File: rtl/dec_stage.sv
// Pipelined RV32I decode stage: decodes the accepted instruction and queues the
// decoded bundle in a DEPTH-entry FIFO towards execute, with a sticky halt on ECALL/EBREAK.
module dec_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  dec_stage_if.slave   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [3:0]      aluOp;
    logic [3:0]      instType;
    logic [3:0]      wbMask;
    logic [1:0]      memSize;
    logic            memSign;
    logic            memWen;
    logic            illegal;
  } entry_t;

  logic [31:0]     w_inst;
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_immI;
  logic [XLEN-1:0] w_immS;
  logic [XLEN-1:0] w_immB;
  logic [XLEN-1:0] w_immJ;
  logic [XLEN-1:0] w_immU;
  logic            w_legal;
  entry_t          w_dec;
  entry_t          w_head;

  entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic            r_halt;

  logic            w_push;
  logic            w_pop;

  assign w_inst   = bus.in_inst;
  assign w_opcode = w_inst[6:0];
  assign w_funct3 = w_inst[14:12];
  assign w_funct7 = w_inst[31:25];

  // Casting a signed value to XLEN sign-extends it for any XLEN >= 32.
  assign w_immI = XLEN'($signed(w_inst[31:20]));
  assign w_immS = XLEN'($signed({w_inst[31:25], w_inst[11:7]}));
  assign w_immB = XLEN'($signed({w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0}));
  assign w_immJ = XLEN'($signed({w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0}));
  assign w_immU = XLEN'($signed({w_inst[31:12], 12'b0}));

  always_comb begin
    w_dec         = '0;
    w_legal       = 1'b1;
    w_dec.pc      = bus.in_pc;
    w_dec.rd      = w_inst[11:7];
    w_dec.rs1     = w_inst[19:15];
    w_dec.rs2     = w_inst[24:20];
    w_dec.memSign = ~w_funct3[2];
    case (w_opcode)
      OPC_OPIMM: begin
        w_dec.instType = 4'd1;
        w_dec.imm      = w_immI;
        w_dec.aluOp    = {w_inst[30] & (w_funct3 == 3'd5), w_funct3};
        if ((w_funct3 == 3'd1) && (w_funct7 != 7'h00))
          w_legal = 1'b0;
        if ((w_funct3 == 3'd5) && (w_funct7 != 7'h00) && (w_funct7 != 7'h20))
          w_legal = 1'b0;
      end
      OPC_OP: begin
        w_dec.instType = 4'd2;
        w_dec.aluOp    = {w_inst[30], w_funct3};
        if (!((w_funct7 == 7'h00) ||
              ((w_funct7 == 7'h20) && ((w_funct3 == 3'd0) || (w_funct3 == 3'd5)))))
          w_legal = 1'b0;
      end
      OPC_LUI: begin
        w_dec.instType = 4'd3;
        w_dec.imm      = w_immU;
      end
      OPC_AUIPC: begin
        w_dec.instType = 4'd4;
        w_dec.imm      = w_immU;
      end
      OPC_JAL: begin
        w_dec.instType = 4'd5;
        w_dec.imm      = w_immJ;
      end
      OPC_JALR: begin
        w_dec.instType = 4'd6;
        w_dec.imm      = w_immI;
      end
      OPC_BRANCH: begin
        w_dec.instType = 4'd7;
        w_dec.imm      = w_immB;
        w_dec.aluOp    = {1'b0, w_funct3};
        if ((w_funct3 == 3'd2) || (w_funct3 == 3'd3))
          w_legal = 1'b0;
      end
      OPC_LOAD: begin
        w_dec.instType = {2'b10, w_funct3[1:0]};
        w_dec.imm      = w_immI;
        w_dec.memSize  = w_funct3[1:0];
        if ((w_funct3 == 3'd3) || (w_funct3 == 3'd6) || (w_funct3 == 3'd7))
          w_legal = 1'b0;
      end
      OPC_STORE: begin
        w_dec.instType = 4'd12;
        w_dec.imm      = w_immS;
        w_dec.memSize  = w_funct3[1:0];
        w_dec.memWen   = 1'b1;
        case (w_funct3[1:0])
          2'd0:    w_dec.wbMask = 4'b0001;
          2'd1:    w_dec.wbMask = 4'b0011;
          2'd2:    w_dec.wbMask = 4'b1111;
          default: w_dec.wbMask = 4'b0000;
        endcase
        if (w_funct3 >= 3'd3)
          w_legal = 1'b0;
      end
      OPC_SYSTEM: begin
        w_dec.instType = 4'd13;
        if ((w_inst != 32'h0000_0073) && (w_inst != 32'h0010_0073))
          w_legal = 1'b0;
      end
      default: w_legal = 1'b0;
    endcase
    // Illegal entries still flow to execute but must never touch memory.
    if (!w_legal) begin
      w_dec.instType = 4'd0;
      w_dec.imm      = '0;
      w_dec.aluOp    = 4'd0;
      w_dec.memSize  = 2'd0;
      w_dec.memWen   = 1'b0;
      w_dec.wbMask   = 4'd0;
      w_dec.illegal  = 1'b1;
    end
  end

  assign bus.in_ready  = (r_count < FULL_CNT) && !r_halt && reset_n;
  assign bus.out_valid = (r_count != '0);
  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_halt  <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_halt  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= w_dec;
        r_wrPtr        <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PTR_W'(1);
        if (w_dec.instType == 4'd13)
          r_halt <= 1'b1;
      end
      if (w_pop)
        r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PTR_W'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - CNT_W'(1);
    end
  end

  assign w_head = r_mem[r_rdPtr];

  assign bus.out_pc      = w_head.pc;
  assign bus.rd          = w_head.rd;
  assign bus.rs1         = w_head.rs1;
  assign bus.rs2         = w_head.rs2;
  assign bus.imm         = w_head.imm;
  assign bus.alu_op      = w_head.aluOp;
  assign bus.inst_type   = w_head.instType;
  assign bus.mem_wbmask  = w_head.wbMask;
  assign bus.mem_size    = w_head.memSize;
  assign bus.is_mem_sign = w_head.memSign;
  assign bus.mem_wen     = w_head.memWen;
  assign bus.illegal     = w_head.illegal;
  assign bus.halt        = r_halt;

endmodule

// File: tb/tb_dec_stage.sv
// Directed self-checking bench for dec_stage: decode fields, FIFO order/wrap,
// halt, flush and asynchronous reset, with hand-computed expectations.
module tb_dec_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic clock;
  logic reset_n;
  logic flush;
  int   checks;
  int   errors;

  dec_stage_if #(.XLEN(XLEN)) bus ();

  dec_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] addiInst(input int k);
    logic [31:0] immVal;
    immVal = k;
    return {immVal[11:0], 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] inst,
                               input logic [31:0] pc, input logic outReady);
    bus.in_valid  = valid;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.out_ready = outReady;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int q[$];
    int nextImm;
    int cyc;
    logic expReady;

    checks        = 0;
    errors        = 0;
    reset_n       = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = 32'h0;
    bus.in_pc     = 32'h0;
    bus.out_ready = 1'b0;

    #2;
    checkOutput("rstValid", bus.out_valid, 1'b0);
    checkOutput("rstReady", bus.in_ready, 1'b0);
    checkOutput("rstHalt", bus.halt, 1'b0);
    checkOutput("rstImm", bus.imm, 32'h0);
    #20 reset_n = 1'b1;

    $display("[TB] addi latency");
    applyStimulus(1'b1, 32'h0050_0093, 32'h100, 1'b1);
    checkOutput("addiValid", bus.out_valid, 1'b1);
    checkOutput("addiType", bus.inst_type, 4'd1);
    checkOutput("addiRd", bus.rd, 5'd1);
    checkOutput("addiImm", bus.imm, 32'd5);
    checkOutput("addiAlu", bus.alu_op, 4'd0);
    checkOutput("addiPc", bus.out_pc, 32'h100);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("addiDrained", bus.out_valid, 1'b0);

    $display("[TB] store and load");
    applyStimulus(1'b1, 32'hFE20_AE23, 32'h104, 1'b1);
    checkOutput("swType", bus.inst_type, 4'd12);
    checkOutput("swImm", bus.imm, 32'hFFFF_FFFC);
    checkOutput("swMask", bus.mem_wbmask, 4'b1111);
    checkOutput("swWen", bus.mem_wen, 1'b1);
    checkOutput("swSize", bus.mem_size, 2'b10);
    applyStimulus(1'b1, 32'h0000_C183, 32'h108, 1'b1);
    checkOutput("lbuType", bus.inst_type, 4'd8);
    checkOutput("lbuSign", bus.is_mem_sign, 1'b0);
    checkOutput("lbuRd", bus.rd, 5'd3);
    checkOutput("lbuRs1", bus.rs1, 5'd1);
    checkOutput("lbuWen", bus.mem_wen, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("lbuDrained", bus.out_valid, 1'b0);

    $display("[TB] fifo full, order and wrap");
    applyStimulus(1'b1, addiInst(1), 32'h200, 1'b0);
    applyStimulus(1'b1, addiInst(2), 32'h204, 1'b0);
    checkOutput("fullReady", bus.in_ready, 1'b0);
    checkOutput("fullValid", bus.out_valid, 1'b1);
    checkOutput("fullHead", bus.imm, 32'd1);
    applyStimulus(1'b1, addiInst(99), 32'h208, 1'b0);
    checkOutput("fullHeadHeld", bus.imm, 32'd1);
    checkOutput("fullStillFull", bus.in_ready, 1'b0);

    q.push_back(1);
    q.push_back(2);
    nextImm = 3;
    cyc = 0;
    bus.out_ready = 1'b1;
    while ((nextImm <= 3 * DEPTH || q.size() > 0) && cyc < 40) begin
      expReady = (q.size() < DEPTH);
      checkOutput("fifoReady", bus.in_ready, expReady);
      checkOutput("fifoValid", bus.out_valid, q.size() > 0);
      if (q.size() > 0)
        checkOutput("fifoOrder", bus.imm, q[0]);
      bus.in_valid = (nextImm <= 3 * DEPTH);
      bus.in_inst  = addiInst(nextImm);
      @(posedge clock);
      #1;
      if (q.size() > 0)
        void'(q.pop_front());
      if (nextImm <= 3 * DEPTH && expReady) begin
        q.push_back(nextImm);
        nextImm++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    checkOutput("fifoDrainBound", q.size(), 0);
    checkOutput("fifoEmpty", bus.out_valid, 1'b0);

    $display("[TB] flush discards queued and incoming entries");
    applyStimulus(1'b1, addiInst(7), 32'h300, 1'b0);
    checkOutput("preFlushValid", bus.out_valid, 1'b1);
    flush = 1'b1;
    applyStimulus(1'b1, addiInst(8), 32'h304, 1'b0);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flushValid", bus.out_valid, 1'b0);
    checkOutput("flushReady", bus.in_ready, 1'b1);

    $display("[TB] ebreak halt");
    applyStimulus(1'b1, 32'h0010_0073, 32'h400, 1'b0);
    checkOutput("ebreakHalt", bus.halt, 1'b1);
    checkOutput("ebreakReady", bus.in_ready, 1'b0);
    checkOutput("ebreakType", bus.inst_type, 4'd13);
    checkOutput("ebreakIllegal", bus.illegal, 1'b0);
    applyStimulus(1'b1, addiInst(9), 32'h404, 1'b0);
    checkOutput("haltHeadType", bus.inst_type, 4'd13);
    checkOutput("haltHeadPc", bus.out_pc, 32'h400);
    applyStimulus(1'b1, addiInst(9), 32'h404, 1'b1);
    checkOutput("haltDrained", bus.out_valid, 1'b0);
    checkOutput("haltSticky", bus.halt, 1'b1);
    checkOutput("haltNoReady", bus.in_ready, 1'b0);
    flush = 1'b1;
    applyStimulus(1'b1, addiInst(9), 32'h404, 1'b1);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flushHalt", bus.halt, 1'b0);
    checkOutput("flushHaltReady", bus.in_ready, 1'b1);
    checkOutput("flushHaltValid", bus.out_valid, 1'b0);

    $display("[TB] illegal and misc decode");
    applyStimulus(1'b1, 32'h0000_707F, 32'h500, 1'b1);
    checkOutput("unkIllegal", bus.illegal, 1'b1);
    checkOutput("unkType", bus.inst_type, 4'd0);
    checkOutput("unkWen", bus.mem_wen, 1'b0);
    applyStimulus(1'b1, 32'h0000_B003, 32'h504, 1'b1);
    checkOutput("ldIllegal", bus.illegal, 1'b1);
    checkOutput("ldType", bus.inst_type, 4'd0);
    checkOutput("ldWen", bus.mem_wen, 1'b0);
    applyStimulus(1'b1, 32'h0000_B023, 32'h508, 1'b1);
    checkOutput("sdIllegal", bus.illegal, 1'b1);
    checkOutput("sdMask", bus.mem_wbmask, 4'd0);
    checkOutput("sdWen", bus.mem_wen, 1'b0);
    applyStimulus(1'b1, 32'h4020_81B3, 32'h50C, 1'b1);
    checkOutput("subType", bus.inst_type, 4'd2);
    checkOutput("subAlu", bus.alu_op, 4'd8);
    checkOutput("subIllegal", bus.illegal, 1'b0);
    applyStimulus(1'b1, 32'h4010_D093, 32'h510, 1'b1);
    checkOutput("sraiType", bus.inst_type, 4'd1);
    checkOutput("sraiAlu", bus.alu_op, 4'hD);
    checkOutput("sraiImm", bus.imm, 32'h0000_0401);
    applyStimulus(1'b1, 32'h3020_0073, 32'h514, 1'b1);
    checkOutput("mretIllegal", bus.illegal, 1'b1);
    checkOutput("mretType", bus.inst_type, 4'd0);
    checkOutput("mretNoHalt", bus.halt, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    checkOutput("illDrained", bus.out_valid, 1'b0);

    $display("[TB] jal, branch, async reset");
    applyStimulus(1'b1, 32'h0080_00EF, 32'h600, 1'b0);
    applyStimulus(1'b1, 32'hFE00_08E3, 32'h604, 1'b0);
    checkOutput("jalValid", bus.out_valid, 1'b1);
    checkOutput("jalType", bus.inst_type, 4'd5);
    checkOutput("jalImm", bus.imm, 32'h0000_0008);
    checkOutput("jalRd", bus.rd, 5'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    bus.out_ready = 1'b0;
    checkOutput("beqType", bus.inst_type, 4'd7);
    checkOutput("beqImm", bus.imm, 32'hFFFF_FFF0);
    checkOutput("beqAlu", bus.alu_op, 4'd0);
    checkOutput("beqPc", bus.out_pc, 32'h604);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("asyncRstValid", bus.out_valid, 1'b0);
    checkOutput("asyncRstReady", bus.in_ready, 1'b0);
    checkOutput("asyncRstImm", bus.imm, 32'h0);
    checkOutput("asyncRstType", bus.inst_type, 4'd0);
    #5 reset_n = 1'b1;
    #10;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
